// File: rtl/nabp_angle_sequencer.sv
// Per-angle scheduler for the filter-mapper shifter: ROM fetch, fill kick, buffer wait, shift kick.
// Optional macro NABP_SEQ_PERF_EN adds the stall_cycles performance counter output.
module nabp_angle_sequencer #(
    parameter int unsigned N_ANGLES    = 180,
    parameter int unsigned ANGLE_W     = 8,
    parameter int unsigned ACCU_W      = 16,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ANGLE_W-1:0] angle_idx,
    output logic [ANGLE_W-1:0] rom_addr,
    input  logic [ACCU_W-1:0]  rom_data,
    output logic [ACCU_W-1:0]  sc_accu_base,
    output logic               sc_fill_kick,
    output logic               sc_shift_kick,
    input  logic               sc_fill_done,
    input  logic               sc_shift_done,
    input  logic               buf_ready
`ifdef NABP_SEQ_PERF_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int unsigned WdogW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WdogW-1:0]   WdogLast  = WdogW'(WDOG_CYCLES - 1);
    localparam logic [ANGLE_W-1:0] LastAngle = ANGLE_W'(N_ANGLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRomRd,
        StRomCap,
        StFillKick,
        StFillWait,
        StBufWait,
        StShiftKick,
        StShiftWait,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ACCU_W-1:0]  base_q, base_d;
    logic [WdogW-1:0]   wdog_q, wdog_d;
    logic               done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            angle_q <= '0;
            base_q  <= '0;
            wdog_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            base_q  <= base_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        base_d  = base_q;
        wdog_d  = wdog_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRomRd;
                    angle_d = '0;
                end
            end
            StRomRd:  state_d = StRomCap;
            StRomCap: begin
                base_d  = rom_data;
                state_d = StFillKick;
            end
            StFillKick: begin
                wdog_d  = '0;
                state_d = StFillWait;
            end
            // A done arriving on the expiring count still wins over the error.
            StFillWait: begin
                if (sc_fill_done) begin
                    state_d = StBufWait;
                end else if (wdog_q == WdogLast) begin
                    state_d = StError;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StBufWait: begin
                if (buf_ready) begin
                    state_d = StShiftKick;
                end
            end
            StShiftKick: begin
                wdog_d  = '0;
                state_d = StShiftWait;
            end
            StShiftWait: begin
                if (sc_shift_done) begin
                    if (angle_q == LastAngle) begin
                        done_d  = 1'b1;
                        angle_d = '0;
                        state_d = StIdle;
                    end else begin
                        angle_d = angle_q + 1'b1;
                        state_d = StRomRd;
                    end
                end else if (wdog_q == WdogLast) begin
                    state_d = StError;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            angle_d = '0;
            wdog_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign busy          = (state_q != StIdle) && (state_q != StError);
    assign err           = (state_q == StError);
    assign done          = done_q;
    assign sc_fill_kick  = (state_q == StFillKick);
    assign sc_shift_kick = (state_q == StShiftKick);
    assign angle_idx     = angle_q;
    assign rom_addr      = angle_q;
    assign sc_accu_base  = base_q;

`ifdef NABP_SEQ_PERF_EN
    // Counts only cycles actually stalled by the downstream buffer.
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (abort) begin
            stall_q <= stall_q;
        end else if (state_q == StIdle && start) begin
            stall_q <= '0;
        end else if (state_q == StBufWait && !buf_ready && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
